data_mem_ctrl: RTL and testbench

- Requester-side sequencer for the 8-entry data_mem. It turns core load/store/clear commands into data_mem port activity and returns read data over a valid/ready handshake.
- Sits between the CPU execute stage and data_mem; sole driver of data_mem datain/address/en.
- Absorbs data_mem's registered read (dataout valid one clock after address with en=0) and sequences the 8 writes of a bulk clear.

---
 rtl/dmem_ctrl_pkg.sv | 23 ++
 rtl/data_mem.sv | 30 +++
 rtl/data_mem_ctrl.sv | 112 +++++++++++
 tb/tb_data_mem_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared types and constants for the data_mem requester
package dmem_ctrl_pkg;

    localparam int DMEM_DEPTH = 8;
    localparam int DMEM_AW    = 3;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_RD_ISSUE   = 3'd2,
        S_RD_CAPTURE = 3'd3,
        S_CLEAR      = 3'd4,
        S_RESP       = 3'd5
    } state_t;

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 8-word data memory, write when en=1, registered read when en=0
module data_mem
    import dmem_ctrl_pkg::*;
#(
    parameter int bits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [bits-1:0]      datain,
    input  logic [DMEM_AW-1:0]   address,
    input  logic                 en,
    output logic [bits-1:0]      dataout
);

    logic [bits-1:0] mem [DMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            dataout <= '0;
        end else if (en) begin
            mem[address] <= datain;
        end else begin
            dataout <= mem[address];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - sequences core load/store/clear commands onto data_mem
module data_mem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int bits  = 8,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [DMEM_AW-1:0]   req_addr,
    input  logic [bits-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [bits-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic [bits-1:0]      mem_datain,
    output logic [DMEM_AW-1:0]   mem_address,
    output logic                 mem_en,
    input  logic [bits-1:0]      mem_dataout
);

    state_t               state;
    logic [DMEM_AW-1:0]   clr_cnt;

    // Every output is a register updated alongside the state transition, so
    // the values seen during a state are the ones that state is defined by.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            mem_en      <= 1'b0;
            mem_address <= '0;
            mem_datain  <= '0;
            clr_cnt     <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        case (op_t'(req_op))
                            OP_LOAD: begin
                                state       <= S_RD_ISSUE;
                                mem_address <= req_addr;
                            end
                            OP_STORE: begin
                                state       <= S_WRITE;
                                mem_en      <= 1'b1;
                                mem_address <= req_addr;
                                mem_datain  <= req_wdata;
                            end
                            OP_CLEAR: begin
                                state       <= S_CLEAR;
                                mem_en      <= 1'b1;
                                mem_address <= '0;
                                mem_datain  <= '0;
                                clr_cnt     <= '0;
                            end
                            default: begin
                                state      <= S_RESP;
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    mem_en     <= 1'b0;
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                end
                S_RD_ISSUE: begin
                    state <= S_RD_CAPTURE;
                end
                S_RD_CAPTURE: begin
                    resp_rdata <= mem_dataout;
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                end
                S_CLEAR: begin
                    // Counter wraps back to 0 on the exit edge after address 7.
                    clr_cnt     <= clr_cnt + 3'd1;
                    mem_address <= clr_cnt + 3'd1;
                    if (clr_cnt == 3'd7) begin
                        mem_en     <= 1'b0;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    resp_err  <= 1'b0;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    mem_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl with data_mem
module tb_data_mem_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [2:0] req_addr = 3'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       resp_valid;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic [7:0] mem_datain;
    logic [2:0] mem_address;
    logic       mem_en;
    logic [7:0] mem_dataout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.bits(8), .DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_datain(mem_datain), .mem_address(mem_address), .mem_en(mem_en),
        .mem_dataout(mem_dataout)
    );

    data_mem #(.bits(8)) u_mem (
        .clk(clk), .reset(reset), .datain(mem_datain), .address(mem_address),
        .en(mem_en), .dataout(mem_dataout)
    );

    // Issues one command at a negedge and watches 12 following negedges.
    // Sample k lies between accept edge T0+k-1 and T0+k.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] addr, input logic [7:0] wd,
                           output int lat, output int pulses, output logic err,
                           output int en_cycles, output logic [7:0] en_mask,
                           output int first_en, output int last_en);
        lat = -1; pulses = 0; err = 1'bx; en_cycles = 0; en_mask = 8'h00;
        first_en = -1; last_en = -1;
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (resp_valid) begin
                pulses++;
                if (lat < 0) begin lat = k; err = resp_err; end
            end
            if (mem_en) begin
                en_cycles++;
                en_mask[mem_address] = 1'b1;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
        n_tests++; if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h exp 00", resp_rdata); end
    endtask

    task automatic test_store_load;
        int lat, pulses, en_cycles, first_en, last_en;
        logic err;
        logic [7:0] mask;
        run_cmd(2'b01, 3'd3, 8'hA5, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL store_latency got %0d exp 2", lat); end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL store_pulses got %0d exp 1", pulses); end
        n_tests++; if (en_cycles !== 1 || mask !== 8'h08) begin n_fail++; $display("FAIL store_write got %0d/%h exp 1/08", en_cycles, mask); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL store_err got %b exp 0", err); end
        n_tests++; if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL store_rdata_kept got %h exp 00", resp_rdata); end
        run_cmd(2'b00, 3'd3, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency got %0d exp 3", lat); end
        n_tests++; if (resp_rdata !== 8'hA5) begin n_fail++; $display("FAIL load_rdata got %h exp a5", resp_rdata); end
        n_tests++; if (en_cycles !== 0) begin n_fail++; $display("FAIL load_no_write got %0d exp 0", en_cycles); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready_after got %b exp 1", req_ready); end
    endtask

    task automatic test_clear;
        int lat, pulses, en_cycles, first_en, last_en;
        logic err;
        logic [7:0] mask;
        for (int i = 0; i < 8; i++)
            run_cmd(2'b01, 3'(i), 8'(8'h11 * (i + 1)), lat, pulses, err, en_cycles, mask, first_en, last_en);
        run_cmd(2'b00, 3'd5, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (resp_rdata !== 8'h66) begin n_fail++; $display("FAIL prefill_rdata got %h exp 66", resp_rdata); end
        run_cmd(2'b10, 3'd0, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL clear_latency got %0d exp 9", lat); end
        n_tests++; if (en_cycles !== 8 || first_en !== 1 || last_en !== 8) begin n_fail++; $display("FAIL clear_en_window got %0d %0d..%0d exp 8 1..8", en_cycles, first_en, last_en); end
        n_tests++; if (mask !== 8'hFF) begin n_fail++; $display("FAIL clear_addr_mask got %h exp ff", mask); end
        n_tests++; if (resp_rdata !== 8'h66) begin n_fail++; $display("FAIL clear_rdata_kept got %h exp 66", resp_rdata); end
        run_cmd(2'b00, 3'd5, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL clear_load5 got %h exp 00", resp_rdata); end
        run_cmd(2'b00, 3'd7, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL clear_load7 got %h exp 00", resp_rdata); end
    endtask

    task automatic test_reserved;
        int lat, pulses, en_cycles, first_en, last_en;
        logic err;
        logic [7:0] mask;
        run_cmd(2'b01, 3'd2, 8'h5A, lat, pulses, err, en_cycles, mask, first_en, last_en);
        run_cmd(2'b00, 3'd2, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (resp_rdata !== 8'h5A) begin n_fail++; $display("FAIL rsvd_pre_rdata got %h exp 5a", resp_rdata); end
        run_cmd(2'b11, 3'd2, 8'hFF, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL rsvd_latency got %0d exp 1", lat); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsvd_err got %b exp 1", err); end
        n_tests++; if (en_cycles !== 0) begin n_fail++; $display("FAIL rsvd_no_write got %0d exp 0", en_cycles); end
        n_tests++; if (resp_rdata !== 8'h5A) begin n_fail++; $display("FAIL rsvd_rdata_kept got %h exp 5a", resp_rdata); end
        run_cmd(2'b01, 3'd4, 8'h77, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b exp 0", err); end
    endtask

    task automatic test_back_to_back;
        int resp_k = -1, acc_k = -1, writes = 0, wr_k = -1, pulses = 0;
        logic [2:0] wr_addr = 3'd0;
        req_op = 2'b00; req_addr = 3'd1; req_wdata = 8'h00; req_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin req_op = 2'b01; req_addr = 3'd6; req_wdata = 8'hC3; end
            if (acc_k >= 0 && k == acc_k + 1) req_valid = 1'b0;
            if (resp_valid) begin pulses++; if (resp_k < 0) resp_k = k; end
            if (mem_en) begin writes++; wr_addr = mem_address; if (wr_k < 0) wr_k = k; end
            if (req_ready && req_valid && acc_k < 0) acc_k = k;
        end
        req_valid = 1'b0;
        n_tests++; if (resp_k !== 3) begin n_fail++; $display("FAIL b2b_load_resp got %0d exp 3", resp_k); end
        n_tests++; if (acc_k !== 4) begin n_fail++; $display("FAIL b2b_accept got %0d exp 4", acc_k); end
        n_tests++; if (writes !== 1 || wr_addr !== 3'd6 || wr_k !== 5) begin n_fail++; $display("FAIL b2b_write got %0d@%0d k=%0d exp 1@6 k=5", writes, wr_addr, wr_k); end
        n_tests++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
        n_tests++; if (resp_rdata !== 8'h00) begin n_fail++; $display("FAIL b2b_load_rdata got %h exp 00", resp_rdata); end
    endtask

    task automatic test_reset_mid_clear;
        int lat, pulses, en_cycles, first_en, last_en, late = 0;
        logic err;
        logic [7:0] mask;
        run_cmd(2'b00, 3'd6, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (resp_rdata !== 8'hC3) begin n_fail++; $display("FAIL b2b_store_data got %h exp c3", resp_rdata); end
        req_op = 2'b10; req_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (resp_valid) late++;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got rdy=%b rv=%b en=%b exp 1 0 0", req_ready, resp_valid, mem_en); end
        n_tests++; if (mem_address !== 3'd0 || resp_rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_regs got a=%0d rd=%h exp 0 00", mem_address, resp_rdata); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resp_valid) late++;
        end
        n_tests++; if (late !== 0) begin n_fail++; $display("FAIL midrst_no_resp got %0d exp 0", late); end
        run_cmd(2'b00, 3'd4, 8'h00, lat, pulses, err, en_cycles, mask, first_en, last_en);
        n_tests++; if (resp_rdata !== 8'h00 || lat !== 3) begin n_fail++; $display("FAIL midrst_mem_zero got %h lat %0d exp 00 lat 3", resp_rdata, lat); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_clear();
        test_reserved();
        test_back_to_back();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
